// File: rtl/irq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : irq_scheduler
// Purpose  : Edge-triggered interrupt collector and vectoring scheduler for
//            cpu_core. Captures rising edges on irq_in into PENDING, picks
//            the lowest enabled pending source while GIE is set, presents
//            cpu_irq together with a vector address, and walks a
//            IDLE -> REQ -> SERVICE handshake with the core. Software access
//            goes through a pipelined Wishbone slave.
// Ports    : clk, rst (async, active-low)
//            irq_in[NUM_IRQ]         interrupt source lines
//            wb_adr_s/wb_in_s/wb_out_s/wb_cyc_s/wb_stb_s/wb_we_s/
//            wb_ack_s/wb_stall_s     Wishbone slave (stall tied 0)
//            cpu_irq, interuptadr    request and vector to cpu_core
//            interrutack, exitint    core accept / handler-done pulses
// Register map (byte address, bits[1:0] ignored):
//            0x00 CTRL bit0 GIE      0x04 ENABLE
//            0x08 PENDING (W1C)      0x0C VECBASE
//            0x10 STATUS (RO): [1:0] state code, [11:8] active id
// Revision : 1.0  initial release
// ============================================================================
module irq_scheduler #(
  parameter int NUM_IRQ     = 8,
  parameter int pc_bit_size = 25,
  parameter int VEC_SHIFT   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_IRQ-1:0]     irq_in,
  input  logic [4:0]             wb_adr_s,
  input  logic [31:0]            wb_in_s,
  output logic [31:0]            wb_out_s,
  input  logic                   wb_cyc_s,
  input  logic                   wb_stb_s,
  input  logic                   wb_we_s,
  output logic                   wb_ack_s,
  output logic                   wb_stall_s,
  output logic                   cpu_irq,
  output logic [pc_bit_size-1:0] interuptadr,
  input  logic                   interrutack,
  input  logic                   exitint
);

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_ENABLE  = 3'd1;
  localparam logic [2:0] A_PENDING = 3'd2;
  localparam logic [2:0] A_VECBASE = 3'd3;
  localparam logic [2:0] A_STATUS  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_gie;
  logic [NUM_IRQ-1:0]     r_enable;
  logic [NUM_IRQ-1:0]     r_pending;
  logic [NUM_IRQ-1:0]     r_irq_q;
  logic [pc_bit_size-1:0] r_vecbase;
  logic [3:0]             r_active_id;

  logic                   w_access;
  logic                   w_wr;
  logic [2:0]             w_reg;
  logic [NUM_IRQ-1:0]     w_edge;
  logic [NUM_IRQ-1:0]     w_w1c;
  logic [NUM_IRQ-1:0]     w_ack_clr;
  logic [NUM_IRQ-1:0]     w_pending_nxt;
  logic [NUM_IRQ-1:0]     w_ready;
  logic [3:0]             w_next_id;
  logic [pc_bit_size-1:0] w_id_ext;
  logic [pc_bit_size-1:0] w_vec_addr;
  logic [31:0]            w_rdata;
  logic                   w_unused;

  assign wb_stall_s = 1'b0;
  assign w_access   = wb_cyc_s & wb_stb_s;
  assign w_wr       = w_access & wb_we_s;
  assign w_reg      = wb_adr_s[4:2];

  // Byte-lane bits of the address and data bits above the widest register
  // carry no meaning here.
  assign w_unused = ^{wb_adr_s[1:0], wb_in_s};

  // ---------------------------------------------------------------------------
  // Pending bookkeeping. Edge sets are OR-ed in last so that a new edge wins
  // over both a software W1C and the hardware clear on core acceptance.
  // ---------------------------------------------------------------------------
  assign w_edge    = irq_in & ~r_irq_q;
  assign w_w1c     = (w_wr && (w_reg == A_PENDING)) ? wb_in_s[NUM_IRQ-1:0] : '0;
  assign w_ack_clr = ((r_state == S_REQ) && interrutack) ?
                     (NUM_IRQ'(1) << r_active_id) : '0;
  assign w_pending_nxt = (r_pending & ~w_w1c & ~w_ack_clr) | w_edge;

  // ---------------------------------------------------------------------------
  // Fixed-priority arbitration: lowest index wins (scan high to low so the
  // last assignment is the lowest set bit).
  // ---------------------------------------------------------------------------
  assign w_ready = r_pending & r_enable;

  always_comb begin
    w_next_id = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_next_id = 4'(i);
      end
    end
  end

  // Vector arithmetic is carried out at the address width so the sum wraps.
  assign w_id_ext   = pc_bit_size'(w_next_id);
  assign w_vec_addr = r_vecbase + (w_id_ext << VEC_SHIFT);

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rdata = 32'd0;
    case (w_reg)
      A_CTRL:    w_rdata = {31'd0, r_gie};
      A_ENABLE:  w_rdata = 32'(r_enable);
      A_PENDING: w_rdata = 32'(r_pending);
      A_VECBASE: w_rdata = 32'(r_vecbase);
      A_STATUS:  w_rdata = {20'd0, r_active_id, 6'd0, r_state};
      default:   w_rdata = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus slave, configuration registers and pending capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gie     <= 1'b0;
      r_enable  <= '0;
      r_pending <= '0;
      r_irq_q   <= '0;
      r_vecbase <= '0;
      wb_ack_s  <= 1'b0;
      wb_out_s  <= 32'd0;
    end else begin
      r_irq_q   <= irq_in;
      r_pending <= w_pending_nxt;
      wb_ack_s  <= w_access;
      wb_out_s  <= (w_access && !wb_we_s) ? w_rdata : 32'd0;
      if (w_wr) begin
        case (w_reg)
          A_CTRL:    r_gie     <= wb_in_s[0];
          A_ENABLE:  r_enable  <= wb_in_s[NUM_IRQ-1:0];
          A_VECBASE: r_vecbase <= wb_in_s[pc_bit_size-1:0];
          default:   ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM. Once a request is raised it is only retired by the core's
  // acceptance, so software changes to GIE/ENABLE/PENDING cannot withdraw it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_active_id <= 4'd0;
      interuptadr <= '0;
      cpu_irq     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_gie && (|w_ready)) begin
            r_active_id <= w_next_id;
            interuptadr <= w_vec_addr;
            cpu_irq     <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (interrutack) begin
            cpu_irq <= 1'b0;
            r_state <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (exitint) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          cpu_irq <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_scheduler
// Purpose  : Self-checking bench for irq_scheduler. A register-access vector
//            table covers reset values, masking and decode; hand-written
//            sequences cover the interrupt handshake corner cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_irq_scheduler;

  localparam int NUM_IRQ = 8;
  localparam int PCW     = 25;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      irq_in = '0;
  logic [4:0]      wb_adr_s = '0;
  logic [31:0]     wb_in_s = '0;
  logic [31:0]     wb_out_s;
  logic            wb_cyc_s = 1'b0;
  logic            wb_stb_s = 1'b0;
  logic            wb_we_s = 1'b0;
  logic            wb_ack_s;
  logic            wb_stall_s;
  logic            cpu_irq;
  logic [PCW-1:0]  interuptadr;
  logic            interrutack = 1'b0;
  logic            exitint = 1'b0;

  int checks = 0;
  int errors = 0;

  irq_scheduler #(.NUM_IRQ(NUM_IRQ), .pc_bit_size(PCW), .VEC_SHIFT(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .wb_adr_s    (wb_adr_s),
    .wb_in_s     (wb_in_s),
    .wb_out_s    (wb_out_s),
    .wb_cyc_s    (wb_cyc_s),
    .wb_stb_s    (wb_stb_s),
    .wb_we_s     (wb_we_s),
    .wb_ack_s    (wb_ack_s),
    .wb_stall_s  (wb_stall_s),
    .cpu_irq     (cpu_irq),
    .interuptadr (interuptadr),
    .interrutack (interrutack),
    .exitint     (exitint)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [4:0]  adr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input bit we, input logic [4:0] adr, input logic [31:0] data,
                     output logic [31:0] rdata);
    wb_cyc_s = 1'b1;
    wb_stb_s = 1'b1;
    wb_we_s  = we;
    wb_adr_s = adr;
    wb_in_s  = data;
    tick();
    wb_cyc_s = 1'b0;
    wb_stb_s = 1'b0;
    wb_we_s  = 1'b0;
    check("bus_ack", 32'(wb_ack_s), 32'd1);
    rdata = wb_out_s;
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] data);
    logic [31:0] d;
    bus(1'b1, adr, data, d);
  endtask

  task automatic rd_check(input string name, input logic [4:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, adr, 32'd0, d);
    check(name, d, exp);
  endtask

  task automatic pulse_ack();
    interrutack = 1'b1;
    tick();
    interrutack = 1'b0;
  endtask

  task automatic pulse_exit();
    exitint = 1'b1;
    tick();
    exitint = 1'b0;
  endtask

  initial begin
    // Register access table: reset values, masking, decode, read-only STATUS.
    tbl[0]  = '{1'b0, 5'h00, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 5'h04, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 5'h08, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 5'h0C, 32'h0,        32'h0};
    tbl[4]  = '{1'b0, 5'h10, 32'h0,        32'h0};
    tbl[5]  = '{1'b1, 5'h0C, 32'hFFFFFFFF, 32'h0};
    tbl[6]  = '{1'b0, 5'h0C, 32'h0,        32'h01FFFFFF};
    tbl[7]  = '{1'b1, 5'h04, 32'hFFFFFFFF, 32'h0};
    tbl[8]  = '{1'b0, 5'h04, 32'h0,        32'h000000FF};
    tbl[9]  = '{1'b1, 5'h00, 32'hFFFFFFFE, 32'h0};
    tbl[10] = '{1'b0, 5'h00, 32'h0,        32'h0};
    tbl[11] = '{1'b1, 5'h14, 32'hDEADBEEF, 32'h0};
    tbl[12] = '{1'b0, 5'h14, 32'h0,        32'h0};
    tbl[13] = '{1'b0, 5'h1C, 32'h0,        32'h0};
    tbl[14] = '{1'b1, 5'h10, 32'hFFFFFFFF, 32'h0};
    tbl[15] = '{1'b0, 5'h10, 32'h0,        32'h0};
    tbl[16] = '{1'b1, 5'h0C, 32'h00001000, 32'h0};
    tbl[17] = '{1'b0, 5'h0F, 32'h0,        32'h00001000};
    tbl[18] = '{1'b1, 5'h04, 32'h00000008, 32'h0};
    tbl[19] = '{1'b0, 5'h04, 32'h0,        32'h00000008};
    tbl[20] = '{1'b1, 5'h00, 32'h00000001, 32'h0};
    tbl[21] = '{1'b0, 5'h00, 32'h0,        32'h00000001};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_irq", 32'(cpu_irq), 32'd0);
    check("rst_vec", 32'(interuptadr), 32'd0);
    check("rst_ack", 32'(wb_ack_s), 32'd0);
    check("rst_out", wb_out_s, 32'd0);
    check("stall", 32'(wb_stall_s), 32'd0);
    rst = 1'b1;

    // ---------------- register table (back-to-back strobes) ----------------
    for (int i = 0; i < 22; i++) begin
      logic [31:0] d;
      bus(tbl[i].we, tbl[i].adr, tbl[i].data, d);
      if (!tbl[i].we) check($sformatf("reg_vec[%0d]", i), d, tbl[i].exp);
    end
    tick();
    check("ack_drops", 32'(wb_ack_s), 32'd0);
    check("no_irq_idle", 32'(cpu_irq), 32'd0);

    // ---------------- basic vectoring, id 3 ----------------
    irq_in = 8'h08;
    tick();                       // edge N: pending
    irq_in = 8'h00;
    check("a_lat_n", 32'(cpu_irq), 32'd0);
    tick();                       // edge N+1: REQ
    check("a_cpu_irq", 32'(cpu_irq), 32'd1);
    check("a_vec", 32'(interuptadr), 32'h1060);
    rd_check("a_status_req", 5'h10, 32'h301);
    rd_check("a_pend_req", 5'h08, 32'h08);
    pulse_ack();
    check("a_irq_low", 32'(cpu_irq), 32'd0);
    rd_check("a_pend_clr", 5'h08, 32'h0);
    rd_check("a_status_svc", 5'h10, 32'h302);
    pulse_ack();                  // ignored outside REQ
    check("a_ack_ign", 32'(cpu_irq), 32'd0);
    pulse_exit();
    tick();
    check("a_idle", 32'(cpu_irq), 32'd0);
    check("a_vec_hold", 32'(interuptadr), 32'h1060);

    // ---------------- simultaneous irq 1 and 5 ----------------
    wr(5'h04, 32'h22);
    irq_in = 8'h22;
    tick();
    irq_in = 8'h00;
    tick();
    check("b_irq1", 32'(cpu_irq), 32'd1);
    check("b_vec1", 32'(interuptadr), 32'h1020);
    pulse_ack();
    check("b_svc1", 32'(cpu_irq), 32'd0);
    pulse_exit();
    check("b_exit_gap", 32'(cpu_irq), 32'd0);
    tick();
    check("b_irq5", 32'(cpu_irq), 32'd1);
    check("b_vec5", 32'(interuptadr), 32'h10A0);
    rd_check("b_status5", 5'h10, 32'h501);
    wr(5'h00, 32'h0);             // GIE off does not withdraw
    wr(5'h04, 32'h0);             // ENABLE off does not withdraw
    check("b_hold_sw", 32'(cpu_irq), 32'd1);
    pulse_exit();                 // ignored in REQ
    check("b_exit_ign", 32'(cpu_irq), 32'd1);
    pulse_ack();
    check("b_svc5", 32'(cpu_irq), 32'd0);
    pulse_exit();
    wr(5'h00, 32'h1);

    // ---------------- vector wrap ----------------
    wr(5'h0C, 32'h01FFFFF0);
    wr(5'h04, 32'h02);
    irq_in = 8'h02;
    tick();
    irq_in = 8'h00;
    tick();
    check("c_irq", 32'(cpu_irq), 32'd1);
    check("c_wrap", 32'(interuptadr), 32'h0000010);
    pulse_ack();
    pulse_exit();
    wr(5'h0C, 32'h1000);

    // ---------------- W1C versus same-cycle edge ----------------
    wr(5'h04, 32'h0);
    irq_in = 8'h04;
    wr(5'h08, 32'h04);
    irq_in = 8'h00;
    rd_check("d_set_wins", 5'h08, 32'h04);
    wr(5'h08, 32'h04);
    rd_check("d_w1c", 5'h08, 32'h0);

    // ---------------- masked source, then enable ----------------
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    check("e_masked", 32'(cpu_irq), 32'd0);
    rd_check("e_pend", 5'h08, 32'h10);
    wr(5'h04, 32'h10);
    check("e_ack_cycle", 32'(cpu_irq), 32'd0);
    tick();
    check("e_irq", 32'(cpu_irq), 32'd1);
    check("e_vec", 32'(interuptadr), 32'h1080);
    pulse_ack();

    // ---------------- re-edge of active id during SERVICE ----------------
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    check("f_no_nest", 32'(cpu_irq), 32'd0);
    rd_check("f_repend", 5'h08, 32'h10);
    rd_check("f_status", 5'h10, 32'h402);
    pulse_exit();
    check("f_exit_gap", 32'(cpu_irq), 32'd0);
    tick();
    check("f_reserve", 32'(cpu_irq), 32'd1);
    pulse_ack();
    rd_check("f_status2", 5'h10, 32'h402);

    // ---------------- async reset during SERVICE ----------------
    #2;
    rst = 1'b0;
    #1;
    check("g_cpu_irq", 32'(cpu_irq), 32'd0);
    check("g_vec", 32'(interuptadr), 32'd0);
    check("g_ack", 32'(wb_ack_s), 32'd0);
    check("g_out", wb_out_s, 32'd0);
    irq_in = 8'h01;               // already high at release
    tick();
    rst = 1'b1;
    pulse_exit();                 // first edge: ignored exit, captures irq 0
    check("g_exit_ign", 32'(cpu_irq), 32'd0);
    rd_check("g_ctrl", 5'h00, 32'h0);
    rd_check("g_enable", 5'h04, 32'h0);
    rd_check("g_pend", 5'h08, 32'h01);
    rd_check("g_vecbase", 5'h0C, 32'h0);
    rd_check("g_status", 5'h10, 32'h0);
    irq_in = 8'h00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_scheduler.md
IRQ_SCHEDULER -- requirements
Module: irq_scheduler

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of interrupt sources (legal 1..16).
REQ-002 Parameter pc_bit_size, default 25, width of the vector address presented to cpu_core.
REQ-003 Parameter VEC_SHIFT, default 5, log2 of the byte spacing between vectors.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 irq_in  in  NUM_IRQ  interrupt source lines, synchronous to clk, rising-edge triggered.
REQ-007 wb_adr_s  in  5  slave byte address; bits[1:0] ignored.
REQ-008 wb_in_s  in  32  write data.  wb_out_s  out  32  read data.
REQ-009 wb_cyc_s, wb_stb_s, wb_we_s  in  1 each  pipelined Wishbone slave controls.
REQ-010 wb_ack_s  out  1  access acknowledge.  wb_stall_s  out  1  tied 0.
REQ-011 cpu_irq  out  1  interrupt request to cpu_core.
REQ-012 interuptadr  out  pc_bit_size  vector address to cpu_core.
REQ-013 interrutack  in  1  core accepted the request (one-cycle pulse).
REQ-014 exitint  in  1  core finished the handler (one-cycle pulse).

Function
REQ-015 Registers (read/write unless noted): 0x00 CTRL bit0 GIE; 0x04 ENABLE[NUM_IRQ-1:0]; 0x08 PENDING (read; write-1-to-clear); 0x0C VECBASE[pc_bit_size-1:0]; 0x10 STATUS (read-only: bits[1:0] state code, bits[11:8] active id).
REQ-016 Unmapped addresses SHALL read 0 and ignore writes; unused register bits read 0.
REQ-017 wb_ack_s SHALL assert exactly one cycle after each cycle with wb_cyc_s&wb_stb_s high, for one cycle per accepted strobe; read data valid with ack.
REQ-018 Back-to-back strobes SHALL each be acked on consecutive cycles.
REQ-019 irq_in SHALL be registered each cycle into irq_q; PENDING[i] set on the clock edge where irq_in[i]&~irq_q[i].
REQ-020 Pending bits SHALL set regardless of ENABLE or GIE.
REQ-021 Same-cycle edge-set and W1C on one bit: set wins.
REQ-022 States: IDLE (code 0), REQ (code 1), SERVICE (code 2).
REQ-023 IDLE: if GIE=1 and (PENDING&ENABLE)!=0, latch lowest set index as active id, go REQ.
REQ-024 cpu_irq SHALL equal (state==REQ); interuptadr SHALL be registered on IDLE->REQ as VECBASE + (id << VEC_SHIFT), truncated modulo 2^pc_bit_size, and held until next IDLE->REQ.
REQ-025 REQ: on interrutack=1, clear PENDING[id] and go SERVICE; otherwise hold. Clearing ENABLE, GIE or PENDING[id] by software while in REQ SHALL NOT withdraw the request.
REQ-026 SERVICE: on exitint=1 go IDLE; new arbitration at earliest the following cycle.
REQ-027 interrutack outside REQ and exitint outside SERVICE SHALL be ignored.
REQ-028 Edge on active id during SERVICE SHALL re-set its pending bit; serviced after exit (no nesting).
REQ-029 Latency: irq_in rising at edge N sample -> pending at N, cpu_irq high after edge N+1 (GIE, ENABLE set, IDLE).

Reset
REQ-030 rst low SHALL immediately force state IDLE, CTRL/ENABLE/PENDING/VECBASE/irq_q/active id to 0, cpu_irq 0, interuptadr 0, wb_ack_s 0, wb_out_s 0, including mid-REQ or mid-SERVICE.
REQ-031 After rst release, irq_in lines already high SHALL NOT produce a pending edge until they fall and rise again... except lines rising after the first post-reset edge (irq_q resets to 0, so a line high at release IS captured as an edge on the first clock).

Verification
REQ-032 VECBASE=0x1000, ENABLE=0x08, GIE=1; pulse irq_in[3] -> cpu_irq high 2 edges later, interuptadr=0x1060; interrutack -> cpu_irq low next cycle, PENDING[3]=0.
REQ-033 Simultaneous edges on irq 1 and 5, both enabled -> vector id 1 first; after exitint, id 5 requested; STATUS shows id 5, state 1.
REQ-034 VECBASE=0x1FFFFF0 (pc_bit_size 25), id 1 -> interuptadr=0x0000010 (wrap).
REQ-035 W1C PENDING[2] in the same cycle as an irq_in[2] edge -> PENDING[2] reads 1.
REQ-036 Assert rst low during SERVICE -> cpu_irq 0, STATUS 0, all registers 0 immediately; post-reset exitint ignored.
REQ-037 ENABLE=0 while irq 4 pends -> no cpu_irq; set ENABLE[4] -> cpu_irq asserts one cycle after the write ack.
